decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all state SHALL update on its rising edge.
REQ-002 The port rstn SHALL be an input, 1 bit wide, and SHALL be a synchronous, active-low reset.
REQ-003 The port in_valid SHALL be an input, 1 bit wide, and SHALL indicate that the upstream (fetch) side presents an instruction.
REQ-004 The port in_ready SHALL be an output, 1 bit wide, driven directly from a register, and SHALL indicate that the stage accepts an instruction this cycle.
REQ-005 The ports inst and pc SHALL be inputs, 32 bits each, carrying the instruction word and its address.
REQ-006 The port flush SHALL be an input, 1 bit wide, and SHALL discard all held instructions.
REQ-007 The port out_valid SHALL be an output, 1 bit wide, and SHALL indicate that the decoded bundle below is valid.
REQ-008 The port out_ready SHALL be an input, 1 bit wide, and SHALL indicate that the execute side consumes the bundle this cycle.
REQ-009 The output bundle SHALL be: aluop (4 bits), rs1, rs2 and rd (5 bits each), imm (32 bits), pc_out (32 bits), use_imm, reg_write, is_branch, is_load, is_store, is_jal, is_jalr, is_lui, is_auipc and illegal (1 bit each).

Function
REQ-010 aluop SHALL use the execute-ALU encoding: ADD=0000, SUB=0001, SLT=0010, XOR=0011, AND=0100, OR=0101, SLL=0110, SRL=0111, SRA=1000, BNE=1001, BLT=1010, BGE=1011.
REQ-011 The supported opcodes SHALL be LUI, AUIPC, JAL, JALR, BRANCH, LW, SW, OP-IMM and OP; every other opcode or funct3/funct7 combination SHALL raise illegal=1 and force reg_write, is_branch, is_load and is_store to 0.
REQ-012 For OP and OP-IMM, aluop SHALL be taken from funct3/funct7; SUB and SRA SHALL require funct7=0100000; SLTU, SLTIU and any other funct7 value SHALL be illegal.
REQ-013 Branch aluop SHALL be chosen so that ALU flag=1 means the branch is taken: BEQ->SUB, BNE->BNE, BLT->BLT, BGE->BGE; BLTU and BGEU SHALL be illegal.
REQ-014 LW, SW, JALR and AUIPC SHALL use aluop=ADD, and use_imm SHALL be 1 for every type except OP and BRANCH.
REQ-015 imm SHALL be the sign-extended I/S/B/J-type immediate or the U-type {inst[31:12],12'b0}, and SHALL be 0 for OP.
REQ-016 A decoded instruction SHALL appear at the outputs one cycle after its in_valid&&in_ready cycle; latency SHALL be exactly 1 when the output is not stalled.
REQ-017 Buffering SHALL consist of an output register and a single skid register; in_ready SHALL equal !skid_valid, registered.
REQ-018 While the output register is empty or out_ready=1, an accepted instruction SHALL load the output register; otherwise it SHALL load the skid register.
REQ-019 When out_valid&&out_ready and skid_valid are both 1, the skid contents SHALL move to the output register in the same cycle, and a simultaneous new input SHALL enter the skid register.
REQ-020 Instruction order SHALL be preserved, and no instruction SHALL be duplicated or dropped except by flush or reset.
REQ-021 The outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 On flush=1, out_valid and skid_valid SHALL clear at the next edge and any input in that cycle SHALL be dropped; flush SHALL take priority over all other events.

Reset
REQ-023 While rstn=0 at a clock edge, out_valid=0, skid_valid=0 and in_ready=1 SHALL apply from the next cycle; the bundle outputs SHALL be 0 and aluop SHALL be ADD.
REQ-024 A reset asserted mid-stall SHALL discard both buffered instructions, and no bundle SHALL be emitted from the pre-reset state.

Structure
REQ-025 The aluop encoding, opcode constants and a decoded-bundle struct typedef SHALL reside in the shared core package, which SHALL also be used by the ALU and the execute stage.
REQ-026 Decoding SHALL be a purely combinational sub-module, decode_comb (inst -> bundle), instantiated once at the input and followed by the output/skid registers.

Verification
REQ-027 The bench SHALL drive inst 0x00500093 (addi x1,x0,5) and check aluop=0000, rd=1, rs1=0, imm=5, use_imm=1, reg_write=1 one cycle later.
REQ-028 The bench SHALL drive inst 0x402081B3 (sub x3,x1,x2) and check aluop=0001, rs1=1, rs2=2, rd=3, use_imm=0, imm=0.
REQ-029 The bench SHALL drive inst 0x0020C463 (blt x1,x2,+8) and check aluop=1010, is_branch=1, imm=8, reg_write=0; it SHALL then drive inst 0xFFFFFFFF and check illegal=1, reg_write=0.
REQ-030 The bench SHALL hold out_ready=0 while presenting A, B and C back-to-back, check in_ready=0 after B is accepted and C held, then raise out_ready and check the outputs emit A, B, C in consecutive cycles.
REQ-031 The bench SHALL assert flush with both registers full and check out_valid=0 and in_ready=1 on the next cycle; it SHALL then assert rstn=0 mid-stall and check the same response with aluop=0000.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: execute-ALU op encoding, RV32I opcode constants and the
// decoded-instruction bundle passed from decode to execute.
package core_pkg;

  typedef enum logic [3:0] {
    AluAdd = 4'b0000,
    AluSub = 4'b0001,
    AluSlt = 4'b0010,
    AluXor = 4'b0011,
    AluAnd = 4'b0100,
    AluOr  = 4'b0101,
    AluSll = 4'b0110,
    AluSrl = 4'b0111,
    AluSra = 4'b1000,
    AluBne = 4'b1001,
    AluBlt = 4'b1010,
    AluBge = 4'b1011
  } alu_op_e;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef struct packed {
    alu_op_e     aluop;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        use_imm;
    logic        reg_write;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic        is_jal;
    logic        is_jalr;
    logic        is_lui;
    logic        is_auipc;
    logic        illegal;
  } bundle_t;

  typedef struct packed {
    logic    illegal;
    alu_op_e op;
  } alu_dec_t;

  // OP-IMM non-shift ops carry immediate bits in funct7, so only OP and shifts check it.
  function automatic alu_dec_t alu_decode(input logic [2:0] funct3, input logic [6:0] funct7,
                                          input logic reg_op);
    alu_dec_t r;
    logic     f7_base;
    logic     f7_alt;
    f7_base   = (funct7 == F7Base);
    f7_alt    = (funct7 == F7Alt);
    r.op      = AluAdd;
    r.illegal = 1'b0;
    case (funct3)
      3'b000: begin
        r.op      = (reg_op && f7_alt) ? AluSub : AluAdd;
        r.illegal = reg_op && !(f7_base || f7_alt);
      end
      3'b001: begin
        r.op      = AluSll;
        r.illegal = !f7_base;
      end
      3'b010: begin
        r.op      = AluSlt;
        r.illegal = reg_op && !f7_base;
      end
      3'b011: r.illegal = 1'b1;
      3'b100: begin
        r.op      = AluXor;
        r.illegal = reg_op && !f7_base;
      end
      3'b101: begin
        r.op      = f7_alt ? AluSra : AluSrl;
        r.illegal = !(f7_base || f7_alt);
      end
      3'b110: begin
        r.op      = AluOr;
        r.illegal = reg_op && !f7_base;
      end
      default: begin
        r.op      = AluAnd;
        r.illegal = reg_op && !f7_base;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I subset decoder: instruction word and pc in, bundle out.
module decode_comb
  import core_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output bundle_t     bundle
);

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  alu_dec_t    alu_dec;

  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign alu_dec = alu_decode(funct3, funct7, inst[6:0] == OpReg);

  always_comb begin
    bundle       = '0;
    bundle.aluop = AluAdd;
    bundle.rs1   = inst[19:15];
    bundle.rs2   = inst[24:20];
    bundle.rd    = inst[11:7];
    bundle.pc    = pc;
    case (inst[6:0])
      OpLui, OpAuipc: begin
        bundle.imm       = imm_u;
        bundle.use_imm   = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.is_lui    = (inst[6:0] == OpLui);
        bundle.is_auipc  = (inst[6:0] == OpAuipc);
      end
      OpJal: begin
        bundle.imm       = imm_j;
        bundle.use_imm   = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.is_jal    = 1'b1;
      end
      OpJalr: begin
        bundle.imm       = imm_i;
        bundle.use_imm   = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.is_jalr   = 1'b1;
        bundle.illegal   = (funct3 != 3'b000);
      end
      OpBranch: begin
        bundle.imm       = imm_b;
        bundle.is_branch = 1'b1;
        // Ops chosen so ALU flag=1 means taken.
        case (funct3)
          3'b000:  bundle.aluop = AluSub;
          3'b001:  bundle.aluop = AluBne;
          3'b100:  bundle.aluop = AluBlt;
          3'b101:  bundle.aluop = AluBge;
          default: bundle.illegal = 1'b1;
        endcase
      end
      OpLoad, OpStore: begin
        bundle.imm      = (inst[6:0] == OpLoad) ? imm_i : imm_s;
        bundle.use_imm  = 1'b1;
        bundle.is_load  = (inst[6:0] == OpLoad);
        bundle.is_store = (inst[6:0] == OpStore);
        bundle.reg_write = (inst[6:0] == OpLoad);
        bundle.illegal  = (funct3 != 3'b010);
      end
      OpImm: begin
        bundle.imm       = imm_i;
        bundle.use_imm   = 1'b1;
        bundle.reg_write = 1'b1;
        bundle.aluop     = alu_dec.op;
        bundle.illegal   = alu_dec.illegal;
      end
      OpReg: begin
        bundle.reg_write = 1'b1;
        bundle.aluop     = alu_dec.op;
        bundle.illegal   = alu_dec.illegal;
      end
      default: bundle.illegal = 1'b1;
    endcase
    if (bundle.illegal) begin
      bundle.reg_write = 1'b0;
      bundle.is_branch = 1'b0;
      bundle.is_load   = 1'b0;
      bundle.is_store  = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: combinational decoder feeding an output register backed by a
// single skid register so in_ready can be fully registered.
module decode_stage
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  aluop,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [31:0] pc_out,
  output logic        use_imm,
  output logic        reg_write,
  output logic        is_branch,
  output logic        is_load,
  output logic        is_store,
  output logic        is_jal,
  output logic        is_jalr,
  output logic        is_lui,
  output logic        is_auipc,
  output logic        illegal
);

  bundle_t dec, out_q, out_d, skid_q, skid_d;
  logic    out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q;
  logic    accept;

  decode_comb u_decode_comb (
    .inst   (inst),
    .pc     (pc),
    .bundle (dec)
  );

  assign accept = in_valid && in_ready_q;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = dec;
      end else begin
        out_valid_d = accept;
        if (accept) out_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign aluop     = out_q.aluop;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign rd        = out_q.rd;
  assign imm       = out_q.imm;
  assign pc_out    = out_q.pc;
  assign use_imm   = out_q.use_imm;
  assign reg_write = out_q.reg_write;
  assign is_branch = out_q.is_branch;
  assign is_load   = out_q.is_load;
  assign is_store  = out_q.is_store;
  assign is_jal    = out_q.is_jal;
  assign is_jalr   = out_q.is_jalr;
  assign is_lui    = out_q.is_lui;
  assign is_auipc  = out_q.is_auipc;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table, stall/flush/reset sequences,
// then random traffic against a mnemonic-level reference model and a FIFO occupancy model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rstn, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] inst, pc, imm, pc_out;
  logic [3:0]  aluop;
  logic [4:0]  rs1, rs2, rd;
  logic        use_imm, reg_write, is_branch, is_load, is_store;
  logic        is_jal, is_jalr, is_lui, is_auipc, illegal;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .pc        (pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .aluop     (aluop),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .imm       (imm),
    .pc_out    (pc_out),
    .use_imm   (use_imm),
    .reg_write (reg_write),
    .is_branch (is_branch),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_jal    (is_jal),
    .is_jalr   (is_jalr),
    .is_lui    (is_lui),
    .is_auipc  (is_auipc),
    .illegal   (illegal)
  );

  typedef struct {
    logic [31:0] inst;
    int          aluop, rs1, rs2, rd;
    logic [31:0] imm;
    bit          imm_chk;
    int          use_imm, reg_write, is_branch, illegal;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] q_inst[$];
  logic [31:0] q_pc[$];
  logic [6:0]  ops[9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic string mnem(input logic [31:0] i);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
    case (i[6:0])
      7'h37: return "lui";
      7'h17: return "auipc";
      7'h6f: return "jal";
      7'h67: return (f3 == 3'd0) ? "jalr" : "ill";
      7'h03: return (f3 == 3'd2) ? "lw" : "ill";
      7'h23: return (f3 == 3'd2) ? "sw" : "ill";
      7'h63: case (f3)
        3'd0: return "beq";
        3'd1: return "bne";
        3'd4: return "blt";
        3'd5: return "bge";
        default: return "ill";
      endcase
      7'h13: case (f3)
        3'd0: return "addi";
        3'd2: return "slti";
        3'd4: return "xori";
        3'd6: return "ori";
        3'd7: return "andi";
        3'd1: return (f7 == 7'h00) ? "slli" : "ill";
        3'd5: return (f7 == 7'h00) ? "srli" : (f7 == 7'h20) ? "srai" : "ill";
        default: return "ill";
      endcase
      7'h33: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: return "add";
            3'd1: return "sll";
            3'd2: return "slt";
            3'd4: return "xor";
            3'd5: return "srl";
            3'd6: return "or";
            3'd7: return "and";
            default: return "ill";
          endcase
        end else if (f7 == 7'h20) begin
          if (f3 == 3'd0) return "sub";
          if (f3 == 3'd5) return "sra";
        end
        return "ill";
      end
      default: return "ill";
    endcase
  endfunction

  // -1: no ALU operation is defined for the mnemonic.
  function automatic int ref_alu(input string m);
    case (m)
      "addi", "add", "lw", "sw", "jalr", "auipc": return 0;
      "sub", "beq":   return 1;
      "slt", "slti":  return 2;
      "xor", "xori":  return 3;
      "and", "andi":  return 4;
      "or", "ori":    return 5;
      "sll", "slli":  return 6;
      "srl", "srli":  return 7;
      "sra", "srai":  return 8;
      "bne":          return 9;
      "blt":          return 10;
      "bge":          return 11;
      default:        return -1;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    int v;
    v = 0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: begin
        v = int'(i[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        v = int'({i[31:25], i[11:7]});
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        v = int'({i[31], i[7], i[30:25], i[11:8]}) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h6f: begin
        v = int'({i[31], i[19:12], i[20], i[30:21]}) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      7'h37, 7'h17: v = int'(i[31:12]) * 4096;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic check_bundle(input logic [31:0] i, input logic [31:0] p);
    string m;
    int    a;
    bit    ill, is_op, is_br, is_st, is_ld;
    m     = mnem(i);
    a     = ref_alu(m);
    ill   = (m == "ill");
    is_op = (i[6:0] == 7'h33);
    is_br = (i[6:0] == 7'h63);
    is_st = (i[6:0] == 7'h23);
    is_ld = (i[6:0] == 7'h03);
    chk("rnd_pc", pc_out, p);
    chk("rnd_illegal", illegal, ill);
    chk("rnd_reg_write", reg_write, !ill && !is_br && !is_st);
    chk("rnd_is_branch", is_branch, !ill && is_br);
    chk("rnd_is_load", is_load, !ill && is_ld);
    chk("rnd_is_store", is_store, !ill && is_st);
    if (!ill) begin
      if (a >= 0) chk("rnd_aluop", aluop, a);
      chk("rnd_imm", imm, ref_imm(i));
      chk("rnd_use_imm", use_imm, !is_op && !is_br);
      chk("rnd_is_jal", is_jal, m == "jal");
      chk("rnd_is_jalr", is_jalr, m == "jalr");
      chk("rnd_is_lui", is_lui, m == "lui");
      chk("rnd_is_auipc", is_auipc, m == "auipc");
      if (!is_br && !is_st) chk("rnd_rd", rd, i[11:7]);
      if (m != "lui" && m != "auipc" && m != "jal") chk("rnd_rs1", rs1, i[19:15]);
      if (is_op || is_br || is_st) chk("rnd_rs2", rs2, i[24:20]);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1;
    inst     = i;
    pc       = p;
    step();
  endtask

  initial begin
    logic [31:0] r;
    bit          mrdy, mvld;

    vecs[0] = '{32'h00500093, 0, 0, -1, 1, 32'd5, 1, 1, 1, 0, 0};
    vecs[1] = '{32'h402081B3, 1, 1, 2, 3, 32'd0, 1, 0, 1, 0, 0};
    vecs[2] = '{32'h0020C463, 10, 1, 2, -1, 32'd8, 1, 0, 0, 1, 0};
    vecs[3] = '{32'hFFFFFFFF, -1, -1, -1, -1, 32'd0, 0, -1, 0, 0, 1};
    vecs[4] = '{32'h123452B7, -1, -1, -1, 5, 32'h12345000, 1, 1, 1, 0, 0};
    vecs[5] = '{32'hFFC12303, 0, 2, -1, 6, 32'hFFFFFFFC, 1, 1, 1, 0, 0};
    vecs[6] = '{32'h003130B3, -1, -1, -1, -1, 32'd0, 0, -1, 0, 0, 1};
    vecs[7] = '{32'h00512423, 0, 2, 5, -1, 32'd8, 1, 1, 0, 0, 0};

    rstn = 1'b0; in_valid = 1'b0; inst = '0; pc = '0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    rstn = 1'b1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_aluop", aluop, 0);
    chk("reset_imm", imm, 0);
    chk("reset_reg_write", reg_write, 0);

    // Decode table, back-to-back with the sink always ready.
    for (int k = 0; k < 8; k++) begin
      push(vecs[k].inst, 32'h1000 + 32'(4 * k));
      chk("vec_out_valid", out_valid, 1);
      chk("vec_pc", pc_out, 32'h1000 + 32'(4 * k));
      if (vecs[k].aluop >= 0) chk("vec_aluop", aluop, vecs[k].aluop);
      if (vecs[k].rs1 >= 0) chk("vec_rs1", rs1, vecs[k].rs1);
      if (vecs[k].rs2 >= 0) chk("vec_rs2", rs2, vecs[k].rs2);
      if (vecs[k].rd >= 0) chk("vec_rd", rd, vecs[k].rd);
      if (vecs[k].imm_chk) chk("vec_imm", imm, vecs[k].imm);
      if (vecs[k].use_imm >= 0) chk("vec_use_imm", use_imm, vecs[k].use_imm);
      chk("vec_reg_write", reg_write, vecs[k].reg_write);
      chk("vec_is_branch", is_branch, vecs[k].is_branch);
      chk("vec_illegal", illegal, vecs[k].illegal);
    end
    in_valid = 1'b0;
    step();
    chk("vec_drain", out_valid, 0);

    // Stall: A, B, C back-to-back with the sink blocked.
    out_ready = 1'b0;
    push(32'h00100093, 32'h200);
    chk("stall_a_valid", out_valid, 1);
    chk("stall_a_ready", in_ready, 1);
    push(32'h00200093, 32'h204);
    chk("stall_b_ready", in_ready, 0);
    chk("stall_b_hold", pc_out, 32'h200);
    push(32'h00300093, 32'h208);
    chk("stall_c_ready", in_ready, 0);
    chk("stall_c_hold_pc", pc_out, 32'h200);
    chk("stall_c_hold_imm", imm, 1);
    out_ready = 1'b1;
    step();
    chk("emit_b_valid", out_valid, 1);
    chk("emit_b_pc", pc_out, 32'h204);
    chk("emit_b_imm", imm, 2);
    step();
    chk("emit_c_valid", out_valid, 1);
    chk("emit_c_pc", pc_out, 32'h208);
    chk("emit_c_imm", imm, 3);
    in_valid = 1'b0;
    step();
    chk("emit_no_dup", out_valid, 0);

    // Flush with both registers full and a simultaneous input.
    out_ready = 1'b0;
    push(32'h402081B3, 32'h300);
    push(32'h402081B3, 32'h304);
    chk("flush_pre_ready", in_ready, 0);
    flush = 1'b1;
    push(32'h00100093, 32'h308);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("flush_no_leak", out_valid, 0);

    // Reset mid-stall.
    out_ready = 1'b0;
    push(32'h402081B3, 32'h400);
    push(32'h402081B3, 32'h404);
    chk("rst_pre_aluop", aluop, 1);
    chk("rst_pre_ready", in_ready, 0);
    rstn = 1'b0; in_valid = 1'b0;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_aluop", aluop, 0);
    rstn = 1'b1; out_ready = 1'b1;
    step(); step();
    chk("rst_no_leak", out_valid, 0);

    // Random traffic against occupancy queue and mnemonic-level decode model.
    q_inst.delete();
    q_pc.delete();
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_out_valid", out_valid, q_inst.size() > 0);
      chk("rnd_in_ready", in_ready, q_inst.size() < 2);
      if (out_valid && q_inst.size() > 0) check_bundle(q_inst[0], q_pc[0]);
      r = $urandom;
      if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 2) == 0) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
      inst      = r;
      pc        = $urandom & 32'hFFFF_FFFC;
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      mrdy = (q_inst.size() < 2);
      mvld = (q_inst.size() > 0);
      if (flush) begin
        q_inst.delete();
        q_pc.delete();
      end else begin
        if (mvld && out_ready) begin
          void'(q_inst.pop_front());
          void'(q_pc.pop_front());
        end
        if (in_valid && mrdy) begin
          q_inst.push_back(inst);
          q_pc.push_back(pc);
        end
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
